hazard_ctrl: RTL

//  Sequencing controller for the 5-stage RV32I pipeline. Generates the stall, flush and forwarding controls.
//  - Stall/flush go to the F/D/E/M/W pipeline registers; forwarding selects go to the Execute-stage operand muxes.
//  - Resolves load-use hazards and taken branches/jumps.
//  - Holds the whole pipeline while a variable-latency data-memory access in M is outstanding, via a req/ready handshake.
//  - A watchdog catches a memory that never answers.

---
 rtl/hazard_ctrl_if.sv | 71 +++++++
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side controls and status.
// Perf counter ports exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
  parameter int A_WIDTH = 5
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
);
  logic [A_WIDTH-1:0] Rs1D, Rs2D;
  logic [A_WIDTH-1:0] Rs1E, Rs2E;
  logic [A_WIDTH-1:0] RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic RegWriteM, RegWriteW;
  logic PCSrcE;
  logic mem_req, mem_ready;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic mem_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
`endif

`ifdef HAZ_PERF_CNT_EN
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E,
    output RdE, RdM, RdW, ResultSrcE,
    output RegWriteM, RegWriteW, PCSrcE,
    output mem_req, mem_ready,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE,
    input  mem_timeout,
    input  stall_cycles, flush_events
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E,
    input  RdE, RdM, RdW, ResultSrcE,
    input  RegWriteM, RegWriteW, PCSrcE,
    input  mem_req, mem_ready,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE,
    output mem_timeout,
    output stall_cycles, flush_events
  );
`else
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E,
    output RdE, RdM, RdW, ResultSrcE,
    output RegWriteM, RegWriteW, PCSrcE,
    output mem_req, mem_ready,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE,
    input  mem_timeout
  );
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E,
    input  RdE, RdM, RdW, ResultSrcE,
    input  RegWriteM, RegWriteW, PCSrcE,
    input  mem_req, mem_ready,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE,
    output mem_timeout
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage stall/flush/forward sequencer with memory-wait watchdog.
// Optional HAZ_PERF_CNT_EN adds stall_cycles / flush_events counters.
module hazard_ctrl #(
  parameter int A_WIDTH     = 5,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_e;

  state_e state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic tmo_q, tmo_d;
  logic lwstall, memwait, run_ev, hold;

  function automatic logic [1:0] fwd_sel(
    input logic [A_WIDTH-1:0] rs
  );
    if (hz.RegWriteM && |hz.RdM &&
        hz.RdM == rs)
      return 2'b10;
    else if (hz.RegWriteW && |hz.RdW &&
             hz.RdW == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign memwait = hz.mem_req && !hz.mem_ready;
  assign lwstall = hz.ResultSrcE == 2'b01 &&
                   |hz.RdE &&
                   (hz.RdE == hz.Rs1D ||
                    hz.RdE == hz.Rs2D);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    run_ev  = 1'b0;
    hold    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (memwait) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
          cnt_d   = TO_W'(1);
        end else begin
          run_ev = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (memwait) begin
          hold = 1'b1;
          if (cnt_q == TO_W'(MEM_TIMEOUT)) begin
            state_d = ERR;
            tmo_d   = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // mem_ready or a dropped req both release
          run_ev  = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      ERR:     hold = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.ForwardAE = fwd_sel(hz.Rs1E);
    hz.ForwardBE = fwd_sel(hz.Rs2E);
    if (rst) begin
      hz.FlushD    = 1'b1;
      hz.FlushE    = 1'b1;
      hz.FlushW    = 1'b1;
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
    end else if (hold) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (run_ev) begin
      if (hz.PCSrcE) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (lwstall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign hz.mem_timeout = tmo_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stc_q, fle_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stc_q <= '0;
      fle_q <= '0;
    end else begin
      if (hz.StallF) stc_q <= stc_q + 1'b1;
      if (hz.FlushE) fle_q <= fle_q + 1'b1;
    end
  end

  assign hz.stall_cycles = stc_q;
  assign hz.flush_events = fle_q;
`endif

endmodule
